// File: rtl/pll_reset_sequencer.sv
// Qualifies the asynchronous PLL lock flag and releases a clean fabric reset once lock has held long enough.
// Define PLL_SEQ_TICK_EN to build the periodic clock-enable tick generator; otherwise tick is constant 0.
module pll_reset_sequencer #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 1024,
   parameter int CNT_W         = 4,
   parameter int TICK_DIV      = 48000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             locked,
   input  logic             clr_lost,
   output logic             sys_rst_n,
   output logic             ready,
   output logic             lock_lost,
   output logic [CNT_W-1:0] loss_count,
   output logic             tick
);
   localparam int               SC_W        = $clog2(STABLE_CYCLES + 1);
   localparam logic [SC_W-1:0]  STABLE_LAST = SC_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      RUN       = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_next_state;
   logic [SYNC_STAGES-1:0] r_sync;
   logic [SC_W-1:0]        r_stable_cnt;
   logic [SC_W-1:0]        w_stable_cnt_next;
   logic                   r_sys_rst_n;
   logic                   r_ready;
   logic                   r_lock_lost;
   logic [CNT_W-1:0]       r_loss_count;
   logic                   w_lock_s;
   logic                   w_next_run;
   logic                   w_loss_event;

   assign w_lock_s     = r_sync[SYNC_STAGES-1];
   assign w_next_run   = (w_next_state == RUN);
   assign w_loss_event = (r_state == RUN) && !w_lock_s;

   // lock synchronizer: the only place the raw lock flag is sampled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= {SYNC_STAGES{1'b0}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], locked};
      end
   end

   // next-state logic; any lock drop outside RUN simply restarts qualification
   always_comb begin
      w_next_state      = WAIT_LOCK;
      w_stable_cnt_next = {SC_W{1'b0}};
      case (r_state)
         WAIT_LOCK: begin
            if (w_lock_s) w_next_state = STABLE;
            else          w_next_state = WAIT_LOCK;
         end
         STABLE: begin
            if (!w_lock_s) begin
               w_next_state = WAIT_LOCK;
            end else if (r_stable_cnt == STABLE_LAST) begin
               w_next_state = RUN;
            end else begin
               w_next_state      = STABLE;
               w_stable_cnt_next = r_stable_cnt + SC_W'(1);
            end
         end
         RUN: begin
            if (w_lock_s) w_next_state = RUN;
            else          w_next_state = WAIT_LOCK;
         end
         default: begin
            w_next_state = WAIT_LOCK;
         end
      endcase
   end

   // state register and registered reset outputs, both driven from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= WAIT_LOCK;
         r_stable_cnt <= {SC_W{1'b0}};
         r_sys_rst_n  <= 1'b0;
         r_ready      <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_stable_cnt <= w_stable_cnt_next;
         r_sys_rst_n  <= w_next_run;
         r_ready      <= w_next_run;
      end
   end

   // loss bookkeeping: a simultaneous clear never hides a new loss event
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lock_lost  <= 1'b0;
         r_loss_count <= {CNT_W{1'b0}};
      end else begin
         if (w_loss_event)  r_lock_lost <= 1'b1;
         else if (clr_lost) r_lock_lost <= 1'b0;
         else               r_lock_lost <= r_lock_lost;
         if (w_loss_event && (r_loss_count != CNT_MAX)) r_loss_count <= r_loss_count + CNT_W'(1);
         else                                           r_loss_count <= r_loss_count;
      end
   end

`ifdef PLL_SEQ_TICK_EN
   localparam int              TK_W      = $clog2(TICK_DIV);
   localparam logic [TK_W-1:0] TICK_LAST = TK_W'(TICK_DIV - 1);

   logic [TK_W-1:0] r_tick_cnt;
   logic            r_tick;
   logic            w_stay_run;
   logic            w_tick_hit;

   assign w_stay_run = (r_state == RUN) && w_next_run;
   assign w_tick_hit = w_stay_run && (r_tick_cnt == TICK_LAST);

   // tick divider runs only while RUN persists; leaving RUN discards the partial period
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tick_cnt <= {TK_W{1'b0}};
         r_tick     <= 1'b0;
      end else begin
         r_tick <= w_tick_hit;
         if (!w_stay_run || w_tick_hit) r_tick_cnt <= {TK_W{1'b0}};
         else                           r_tick_cnt <= r_tick_cnt + TK_W'(1);
      end
   end

   assign tick = r_tick;
`else
   // TICK_DIV is a positive period, so this folds to constant 0
   assign tick = (TICK_DIV < 0) ? 1'b1 : 1'b0;
`endif

   assign sys_rst_n  = r_sys_rst_n;
   assign ready      = r_ready;
   assign lock_lost  = r_lock_lost;
   assign loss_count = r_loss_count;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomized and directed bench for pll_reset_sequencer, checked against a run-length reference model.
module tb_pll_reset_sequencer;
   localparam int SS = 2;
   localparam int SC = 8;
   localparam int CW = 2;
   localparam int TD = 4;
   localparam int CNT_SAT = (1 << CW) - 1;
`ifdef PLL_SEQ_TICK_EN
   localparam bit TICK_ON = 1'b1;
`else
   localparam bit TICK_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          locked;
   logic          clr_lost;
   logic          sys_rst_n;
   logic          ready;
   logic          lock_lost;
   logic [CW-1:0] loss_count;
   logic          tick;

   pll_reset_sequencer #(
      .SYNC_STAGES  (SS),
      .STABLE_CYCLES(SC),
      .CNT_W        (CW),
      .TICK_DIV     (TD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .locked    (locked),
      .clr_lost  (clr_lost),
      .sys_rst_n (sys_rst_n),
      .ready     (ready),
      .lock_lost (lock_lost),
      .loss_count(loss_count),
      .tick      (tick)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: RUN holds once the synchronized lock has been high for SC+1 consecutive edges
   bit [SS-1:0] m_sync;
   int          m_run_len;
   bit          m_ready;
   bit          m_lost;
   int          m_loss_cnt;
   bit          m_tick;

   int edges;
   int ticks;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic model_reset();
      m_sync     = '0;
      m_run_len  = 0;
      m_ready    = 1'b0;
      m_lost     = 1'b0;
      m_loss_cnt = 0;
      m_tick     = 1'b0;
   endtask

   task automatic model_edge();
      bit ls;
      bit loss;
      ls        = m_sync[SS-1];
      m_sync    = {m_sync[SS-2:0], locked};
      loss      = m_ready && !ls;
      m_run_len = ls ? m_run_len + 1 : 0;
      m_ready   = (m_run_len >= SC + 1);
      if (loss)          m_lost = 1'b1;
      else if (clr_lost) m_lost = 1'b0;
      if (loss && m_loss_cnt < CNT_SAT) m_loss_cnt++;
      m_tick = TICK_ON && m_ready && (m_run_len > SC + 1) && (((m_run_len - SC - 1) % TD) == 0);
   endtask

   task automatic check_all();
      chk("sys_rst_n", sys_rst_n, m_ready);
      chk("ready", ready, m_ready);
      chk("lock_lost", lock_lost, m_lost);
      chk("loss_count", loss_count, m_loss_cnt);
      chk("tick", tick, m_tick);
   endtask

   task automatic step(input logic lk, input logic clr);
      locked   = lk;
      clr_lost = clr;
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      check_all();
   endtask

   task automatic async_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      #1;
      rst_n = 1'b1;
   endtask

   task automatic do_reset(input int n);
      locked   = 1'b0;
      clr_lost = 1'b0;
      rst_n    = 1'b0;
      #1;
      model_reset();
      check_all();
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
      rst_n = 1'b1;
   endtask

   // count edges of steady lock until the fabric reset releases (bounded)
   task automatic wait_rise(input logic clr);
      edges = 0;
      for (int i = 0; i < 40; i++) begin
         step(1'b1, clr);
         edges++;
         if (sys_rst_n === 1'b1) break;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // cold start
      do_reset(3);
      wait_rise(1'b0);
      chk("cold_latency", edges, 11);
      ticks = 0;
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 1'b0);
         if (tick === 1'b1) ticks++;
      end
      chk("tick_count", ticks, TICK_ON ? 3 : 0);

      // lock loss
      edges = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0);
         edges++;
         if (sys_rst_n === 1'b0) break;
      end
      chk("loss_latency", edges, 3);
      chk("loss_flag", lock_lost, 1);
      chk("loss_cnt1", loss_count, 1);

      // clear with no event
      step(1'b0, 1'b1);
      chk("clr_plain", lock_lost, 0);

      // glitch rejection
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      wait_rise(1'b0);
      chk("glitch_latency", edges, 11);
      chk("glitch_no_loss", lock_lost, 0);

      // repeated losses, one with a coincident clear
      for (int k = 0; k < 4; k++) begin
         if (k > 0) wait_rise(1'b0);
         chk("relock", sys_rst_n, 1);
         step(1'b0, 1'b0);
         step(1'b0, 1'b0);
         step(1'b0, (k == 2) ? 1'b1 : 1'b0);
         if (k == 2) chk("clr_vs_loss", lock_lost, 1);
      end
      chk("loss_sat", loss_count, CNT_SAT);

      // loss in the middle of a tick period
      wait_rise(1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
      wait_rise(1'b0);
      ticks = 0;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0);
         if (tick === 1'b1) ticks = i + 1;
      end
      chk("tick_after_relock", ticks, TICK_ON ? 4 : 0);

      // reset mid-STABLE (stable count 5 after edge 8)
      do_reset(2);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
      async_reset();
      chk("mid_rst_ready", ready, 0);
      wait_rise(1'b0);
      chk("restart_latency", edges, 11);

      // randomized lock behaviour with occasional clears and resets
      for (int r = 0; r < 60; r++) begin
         int   hold;
         logic lk;
         hold = $urandom_range(1, 25);
         lk   = ($urandom_range(0, 3) != 0);
         for (int j = 0; j < hold; j++) begin
            step(lk, ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 249) == 0) async_reset();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the HSOSC/PLL clock stage.
- Runs on the PLL global clock output.
- Takes the asynchronous PLL lock flag, synchronizes and qualifies it, and releases a clean system reset to the fabric only after lock has held for a programmable time.
- Tracks lock-loss events, and optionally generates a periodic clock-enable tick for slow logic (LED/display scan, debounce).

Parameters:
- SYNC_STAGES, 2, number of flops in the lock synchronizer (min 2).
- STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before reset release (min 1).
- CNT_W, 4, width of the saturating lock-loss counter.
- TICK_DIV, 48000, tick period in clk cycles (min 2; 1 ms at 48 MHz).

Ports:
- clk, input, 1, PLL global output clock; all logic is on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- locked, input, 1, raw PLL lock; asynchronous to clk.
- clr_lost, input, 1, single-cycle pulse that clears lock_lost.
- sys_rst_n, output, 1, registered active-low system reset for the fabric; high only in RUN.
- ready, output, 1, equals state==RUN (registered, identical timing to sys_rst_n).
- lock_lost, output, 1, sticky flag: lock dropped while in RUN.
- loss_count, output, CNT_W, saturating count of RUN-to-lock-loss events.
- tick, output, 1, one-cycle clock-enable pulse every TICK_DIV cycles while in RUN.

Behaviour:
- Reset: rst_n low asynchronously clears all flops.
  - State = WAIT_LOCK, sync chain = 0, stable counter = 0.
  - sys_rst_n = 0, ready = 0, lock_lost = 0, loss_count = 0, tick = 0, tick counter = 0.
- lock_s is the last stage of the SYNC_STAGES-flop chain sampling locked. No other logic samples locked directly.
- WAIT_LOCK:
  - If lock_s = 1, go to STABLE with stable counter = 0.
  - Otherwise stay.
- STABLE:
  - If lock_s = 0, go to WAIT_LOCK and clear the counter (glitch rejection, no loss event counted).
  - Else if counter == STABLE_CYCLES-1, go to RUN.
  - Else counter increments.
- RUN:
  - If lock_s = 0, go to WAIT_LOCK.
  - On that same edge: sys_rst_n and ready go 0, lock_lost is set, and loss_count increments, saturating at 2^CNT_W-1.
- Latency, locked rising: locked is first sampled high at edge 1. sys_rst_n rises at edge SYNC_STAGES+STABLE_CYCLES+1, provided locked stays high throughout.
- Latency, locked falling: locked is first sampled low at edge 1. sys_rst_n falls at edge SYNC_STAGES+1.
- lock_lost:
  - clr_lost clears it on the next edge.
  - If clr_lost and a loss event occur on the same edge, set wins (lock_lost = 1).
- loss_count is never cleared except by rst_n.
- Tick counter:
  - Counts 0..TICK_DIV-1 only in RUN, and wraps to 0.
  - tick = 1 for the one cycle the counter equals TICK_DIV-1.
  - Outside RUN, the counter is held at 0 and tick = 0. Leaving RUN mid-period discards the partial count.
- rst_n asserted mid-sequence (any state): immediate return to the full reset values; the sequence restarts from WAIT_LOCK.
- Unused or illegal state encodings transition to WAIT_LOCK with sys_rst_n = 0.

Optional Feature:
- Macro: PLL_SEQ_TICK_EN.
- Defined: the tick counter and tick output behave as described above.
- Undefined: no tick counter is built; tick is tied to constant 0; TICK_DIV is ignored.

Test Plan (SYNC_STAGES=2, STABLE_CYCLES=8, CNT_W=2, TICK_DIV=4, macro defined):
- Cold start: rst_n low 3 cycles, then high; locked held high from the first edge -> sys_rst_n = 0 and ready = 0 through edge 10, both = 1 at edge 11; loss_count = 0.
- Lock glitch: locked high 5 cycles, low 1 cycle, then high steadily -> glitch is rejected; the stable count restarts; sys_rst_n rises 11 edges after locked re-rises; lock_lost stays 0.
- Lock loss: in RUN, drop locked -> sys_rst_n = 0 at the 3rd edge; lock_lost = 1; loss_count = 1. Repeat 4 losses -> loss_count saturates at 3.
- Clear priority: pulse clr_lost with no event -> lock_lost = 0 next edge. Pulse clr_lost on the same edge as a loss -> lock_lost = 1.
- Tick: in RUN, tick pulses on edges 4, 8, 12 after sys_rst_n rises. Lock loss at edge 6 -> no further ticks; the first tick after relock comes 4 edges after sys_rst_n re-rises.
- Reset mid-STABLE: assert rst_n at stable count 5 -> all outputs return to reset values immediately; the full 11-edge sequence is required again. Rerun with the macro undefined -> tick is constant 0.
